// File: rtl/bus_sequencer_pkg.sv
// Shared Bus codes, legality checks and stage record for the bus sequencer.
package bus_sequencer_pkg;

  localparam int NUM_REQ = 3;
  localparam int SRC_W   = 4;
  localparam int DST_W   = 3;

  localparam logic [SRC_W-1:0] SRC_HOLD  = 4'b0000;
  localparam logic [SRC_W-1:0] SRC_AC    = 4'b0001;
  localparam logic [SRC_W-1:0] SRC_R1    = 4'b0010;
  localparam logic [SRC_W-1:0] SRC_R2    = 4'b0011;
  localparam logic [SRC_W-1:0] SRC_MDR   = 4'b0101;
  localparam logic [SRC_W-1:0] SRC_SR1   = 4'b0110;
  localparam logic [SRC_W-1:0] SRC_SR2   = 4'b0111;
  localparam logic [SRC_W-1:0] SRC_SR3   = 4'b1000;
  localparam logic [SRC_W-1:0] SRC_RRR   = 4'b1001;
  localparam logic [SRC_W-1:0] SRC_CRR   = 4'b1010;
  localparam logic [SRC_W-1:0] SRC_CONST = 4'b1011;

  localparam logic [DST_W-1:0] DST_NONE = 3'b000;
  localparam logic [DST_W-1:0] DST_R1   = 3'b010;
  localparam logic [DST_W-1:0] DST_R2   = 3'b011;
  localparam logic [DST_W-1:0] DST_SR1  = 3'b110;

  // A rejected request still owns S (owner set) but with legal cleared.
  typedef struct packed {
    logic [NUM_REQ-1:0] owner;
    logic               legal;
    logic [SRC_W-1:0]   src;
    logic [DST_W-1:0]   dst;
  } s_stage_t;

  function automatic logic src_legal(input logic [SRC_W-1:0] code);
    case (code)
      SRC_AC, SRC_R1, SRC_R2, SRC_MDR, SRC_SR1,
      SRC_SR2, SRC_SR3, SRC_RRR, SRC_CRR, SRC_CONST: src_legal = 1'b1;
      default:                                       src_legal = 1'b0;
    endcase
  endfunction

  function automatic logic dst_legal(input logic [DST_W-1:0] code);
    case (code)
      DST_R1, DST_R2, DST_SR1: dst_legal = 1'b1;
      default:                 dst_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    case (oh)
      3'b010:  onehot_to_idx = 2'd1;
      3'b100:  onehot_to_idx = 2'd2;
      default: onehot_to_idx = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/bus_sequencer_if.sv
// Requester-side handshake and Bus select signals of the bus sequencer.
interface bus_sequencer_if;
  import bus_sequencer_pkg::*;

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*SRC_W-1:0] req_src;
  logic [NUM_REQ*DST_W-1:0] req_dst;
  logic [NUM_REQ-1:0]       ack;
  logic [NUM_REQ-1:0]       err;
  logic [SRC_W-1:0]         bus_select_source;
  logic [DST_W-1:0]         bus_select_destination;
  logic                     busy;
  logic [15:0]              xfer_count;

  modport master (
    output req, req_src, req_dst,
    input  ack, err, bus_select_source, bus_select_destination, busy, xfer_count
  );

  modport slave (
    input  req, req_src, req_dst,
    output ack, err, bus_select_source, bus_select_destination, busy, xfer_count
  );

endinterface

// File: rtl/bus_sequencer_rr_arbiter3.sv
// Three-way round-robin arbiter; search starts after the last granted index.
module rr_arbiter3
  import bus_sequencer_pkg::*;
(
  input  logic                clock,
  input  logic                reset_n,
  input  logic [NUM_REQ-1:0]  req,
  output logic [NUM_REQ-1:0]  grant
);

  logic [1:0]         ptr_r;
  logic [NUM_REQ-1:0] grant_s;

  // Priority order rotates with the pointer of the last grant.
  always_comb begin
    grant_s = 3'b000;
    case (ptr_r)
      2'd0: begin
        if (req[1])      grant_s = 3'b010;
        else if (req[2]) grant_s = 3'b100;
        else if (req[0]) grant_s = 3'b001;
        else             grant_s = 3'b000;
      end
      2'd1: begin
        if (req[2])      grant_s = 3'b100;
        else if (req[0]) grant_s = 3'b001;
        else if (req[1]) grant_s = 3'b010;
        else             grant_s = 3'b000;
      end
      default: begin
        if (req[0])      grant_s = 3'b001;
        else if (req[1]) grant_s = 3'b010;
        else if (req[2]) grant_s = 3'b100;
        else             grant_s = 3'b000;
      end
    endcase
  end

  // Pointer resets to 2 so requester 0 is searched first.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)     ptr_r <= 2'd2;
    else if (|grant_s) ptr_r <= onehot_to_idx(grant_s);
    else              ptr_r <= ptr_r;
  end

  assign grant = grant_s;

endmodule

// File: rtl/bus_sequencer.sv
// Two-stage Bus transfer sequencer: grant into S (source select), then D (destination select + ack).
module bus_sequencer
  import bus_sequencer_pkg::*;
#(
  parameter int NREQ = NUM_REQ
) (
  input  logic             clock,
  input  logic             reset_n,
  bus_sequencer_if.slave   bus
);

  logic [NREQ-1:0]  mask_s;
  logic [NREQ-1:0]  grant_s;
  logic [SRC_W-1:0] gsrc_s;
  logic [DST_W-1:0] gdst_s;
  logic             legal_s;
  logic             d_load_s;
  s_stage_t         s_next_s;
  s_stage_t         s_r;
  logic [NREQ-1:0]  ack_r;
  logic [NREQ-1:0]  err_r;
  logic [DST_W-1:0] d_dst_r;
  logic [15:0]      count_r;
  logic             busy_r;

  // ack_r doubles as the one-hot owner of the D stage.
  assign mask_s   = s_r.owner | ack_r;
  assign d_load_s = (|s_r.owner) & s_r.legal;

  rr_arbiter3 u_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (bus.req & ~mask_s),
    .grant   (grant_s)
  );

  // Select the winner's codes and build the next S-stage record.
  always_comb begin
    gsrc_s = SRC_HOLD;
    gdst_s = DST_NONE;
    case (grant_s)
      3'b001: begin gsrc_s = bus.req_src[3:0];  gdst_s = bus.req_dst[2:0]; end
      3'b010: begin gsrc_s = bus.req_src[7:4];  gdst_s = bus.req_dst[5:3]; end
      3'b100: begin gsrc_s = bus.req_src[11:8]; gdst_s = bus.req_dst[8:6]; end
      default: begin gsrc_s = SRC_HOLD; gdst_s = DST_NONE; end
    endcase
    legal_s        = (|grant_s) & src_legal(gsrc_s) & dst_legal(gdst_s);
    s_next_s.owner = grant_s;
    s_next_s.legal = legal_s;
    if (legal_s) begin
      s_next_s.src = gsrc_s;
      s_next_s.dst = gdst_s;
    end else begin
      s_next_s.src = SRC_HOLD;
      s_next_s.dst = DST_NONE;
    end
  end

  // Pipeline advance; rejected requests stop in S and never reach D.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s_r     <= '{owner: 3'b000, legal: 1'b0, src: SRC_HOLD, dst: DST_NONE};
      err_r   <= 3'b000;
      ack_r   <= 3'b000;
      d_dst_r <= DST_NONE;
      count_r <= 16'd0;
      busy_r  <= 1'b0;
    end else begin
      s_r     <= s_next_s;
      err_r   <= legal_s ? 3'b000 : grant_s;
      ack_r   <= d_load_s ? s_r.owner : 3'b000;
      d_dst_r <= d_load_s ? s_r.dst : DST_NONE;
      count_r <= d_load_s ? count_r + 16'd1 : count_r;
      busy_r  <= (|grant_s) | d_load_s;
    end
  end

  assign bus.ack                    = ack_r;
  assign bus.err                    = err_r;
  assign bus.bus_select_source      = s_r.src;
  assign bus.bus_select_destination = d_dst_r;
  assign bus.busy                   = busy_r;
  assign bus.xfer_count             = count_r;

endmodule

// File: tb/tb_bus_sequencer.sv
// Scoreboard bench: directed stimulus pushes expected S/D events, a negedge monitor pops and compares.
module tb_bus_sequencer
  import bus_sequencer_pkg::*;
;

  typedef struct packed { logic [3:0] src; logic [2:0] err; } s_exp_t;
  typedef struct packed { logic [2:0] ack; logic [2:0] dst; logic [15:0] cnt; } d_exp_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   checks  = 0;
  int   errors  = 0;
  logic [15:0] exp_cnt = 16'd0;
  s_exp_t s_q[$];
  d_exp_t d_q[$];
  s_exp_t mon_se;
  d_exp_t mon_de;
  logic [3:0] srcs[3];
  logic [2:0] dsts[3];

  bus_sequencer_if bus_if ();

  bus_sequencer #(.NREQ(3)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_if.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_ok(input int idx, input logic [3:0] src, input logic [2:0] dst);
    logic [2:0] oh;
    oh = 3'b001 << idx;
    s_q.push_back('{src: src, err: 3'b000});
    exp_cnt = exp_cnt + 16'd1;
    d_q.push_back('{ack: oh, dst: dst, cnt: exp_cnt});
  endtask

  task automatic exp_err(input int idx);
    logic [2:0] oh;
    oh = 3'b001 << idx;
    s_q.push_back('{src: SRC_HOLD, err: oh});
  endtask

  task automatic step(input logic [2:0] r);
    bus_if.req = r;
    @(posedge clock);
    #1;
  endtask

  // Monitor: any S presentation (source or err) and any ack must match the head of its queue.
  always @(negedge clock) begin
    if (reset_n) begin
      if (bus_if.bus_select_source != 4'd0 || bus_if.err != 3'd0) begin
        if (s_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL s_event: got src %0h err %0h, required no event at %0t",
                   bus_if.bus_select_source, bus_if.err, $time);
        end else begin
          mon_se = s_q.pop_front();
          chk("s_src", 32'(bus_if.bus_select_source), 32'(mon_se.src));
          chk("s_err", 32'(bus_if.err), 32'(mon_se.err));
        end
      end
      if (bus_if.ack != 3'd0) begin
        if (d_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL d_event: got ack %0h dst %0h, required no event at %0t",
                   bus_if.ack, bus_if.bus_select_destination, $time);
        end else begin
          mon_de = d_q.pop_front();
          chk("d_ack", 32'(bus_if.ack), 32'(mon_de.ack));
          chk("d_dst", 32'(bus_if.bus_select_destination), 32'(mon_de.dst));
          chk("d_count", 32'(bus_if.xfer_count), 32'(mon_de.cnt));
        end
      end else if (bus_if.bus_select_destination != 3'd0) begin
        checks++; errors++;
        $display("FAIL d_idle: got dst %0h with no ack, required 0", bus_if.bus_select_destination);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    srcs = '{SRC_AC, SRC_R1, SRC_R2};
    dsts = '{DST_R1, DST_R2, DST_SR1};
    bus_if.req     = 3'b000;
    bus_if.req_src = {SRC_R2, SRC_R1, SRC_AC};
    bus_if.req_dst = {DST_SR1, DST_R2, DST_R1};
    repeat (3) @(posedge clock);
    #1;
    chk("rst_ack", 32'(bus_if.ack), 32'd0);
    chk("rst_err", 32'(bus_if.err), 32'd0);
    chk("rst_src", 32'(bus_if.bus_select_source), 32'd0);
    chk("rst_dst", 32'(bus_if.bus_select_destination), 32'd0);
    chk("rst_busy", 32'(bus_if.busy), 32'd0);
    chk("rst_count", 32'(bus_if.xfer_count), 32'd0);
    reset_n = 1'b1;

    // Single transfer from requester 0.
    exp_ok(0, SRC_AC, DST_R1);
    step(3'b001);
    chk("a_busy", 32'(bus_if.busy), 32'd1);
    chk("a_dst_empty", 32'(bus_if.bus_select_destination), 32'd0);
    step(3'b001);
    chk("a_count", 32'(bus_if.xfer_count), 32'd1);
    step(3'b001);
    step(3'b000);
    step(3'b000);
    chk("a_idle_busy", 32'(bus_if.busy), 32'd0);

    // Illegal source on requester 1, then illegal destination on requester 2.
    bus_if.req_src = {SRC_R2, 4'b0100, SRC_AC};
    exp_err(1);
    step(3'b010);
    step(3'b010);
    step(3'b000);
    chk("c_count", 32'(bus_if.xfer_count), 32'(exp_cnt));
    bus_if.req_src = {SRC_R2, SRC_R1, SRC_AC};
    bus_if.req_dst = {DST_NONE, DST_R2, DST_R1};
    exp_err(2);
    step(3'b100);
    step(3'b100);
    step(3'b000);
    chk("c_count2", 32'(bus_if.xfer_count), 32'(exp_cnt));
    bus_if.req_dst = {DST_SR1, DST_R2, DST_R1};

    // Requester 0 holds req past its ack; pending requester 2 wins next.
    exp_ok(0, SRC_AC, DST_R1);
    step(3'b001);
    step(3'b001);
    exp_ok(2, SRC_R2, DST_SR1);
    step(3'b101);
    chk("d_second", 32'(bus_if.bus_select_source), 32'(SRC_R2));
    step(3'b100);
    step(3'b100);
    step(3'b000);
    step(3'b000);

    // Reset during the D cycle drops the transfer.
    s_q.push_back('{src: SRC_AC, err: 3'b000});
    step(3'b001);
    step(3'b001);
    chk("e_dst_before", 32'(bus_if.bus_select_destination), 32'(DST_R1));
    #1;
    reset_n = 1'b0;
    bus_if.req = 3'b000;
    exp_cnt = 16'd0;
    #1;
    chk("e_dst_rst", 32'(bus_if.bus_select_destination), 32'd0);
    chk("e_ack_rst", 32'(bus_if.ack), 32'd0);
    chk("e_count_rst", 32'(bus_if.xfer_count), 32'd0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // All three requesting after release: grants 0,1,2,0 with no idle gap.
    exp_ok(0, SRC_AC, DST_R1);
    exp_ok(1, SRC_R1, DST_R2);
    exp_ok(2, SRC_R2, DST_SR1);
    exp_ok(0, SRC_AC, DST_R1);
    step(3'b111);
    chk("b_src1", 32'(bus_if.bus_select_source), 32'(SRC_AC));
    chk("b_dst1", 32'(bus_if.bus_select_destination), 32'd0);
    step(3'b111);
    chk("b_src2", 32'(bus_if.bus_select_source), 32'(SRC_R1));
    chk("b_dst2", 32'(bus_if.bus_select_destination), 32'(DST_R1));
    step(3'b111);
    chk("b_src3", 32'(bus_if.bus_select_source), 32'(SRC_R2));
    chk("b_dst3", 32'(bus_if.bus_select_destination), 32'(DST_R2));
    step(3'b111);
    chk("b_src4", 32'(bus_if.bus_select_source), 32'(SRC_AC));
    chk("b_dst4", 32'(bus_if.bus_select_destination), 32'(DST_SR1));
    step(3'b000);
    chk("b_src5", 32'(bus_if.bus_select_source), 32'd0);
    chk("b_dst5", 32'(bus_if.bus_select_destination), 32'(DST_R1));
    chk("b_count", 32'(bus_if.xfer_count), 32'd4);
    step(3'b000);
    step(3'b000);

    // Sustained traffic until the counter wraps through 0xFFFF to 0.
    for (int k = 0; k < 65532; k++) begin
      exp_ok((k + 1) % 3, srcs[(k + 1) % 3], dsts[(k + 1) % 3]);
      step(3'b111);
    end
    step(3'b000);
    step(3'b000);
    step(3'b000);
    chk("f_count_wrap", 32'(bus_if.xfer_count), 32'd0);
    chk("f_busy", 32'(bus_if.busy), 32'd0);
    chk("s_q_drained", 32'(s_q.size()), 32'd0);
    chk("d_q_drained", 32'(d_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
